control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/control_unit.sv | 175 +++++++++++++++++
 tb/tb_control_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control FSM state encoding plus the opcode, funct
// and ALUOp constants used by the control unit and the ALU control decoder.
package cpu_pkg;

    typedef enum logic [4:0] {
        ST_FETCH       = 5'd0,
        ST_FETCH_WAIT  = 5'd1,
        ST_DECODE      = 5'd2,
        ST_EXEC_R      = 5'd3,
        ST_WB_R        = 5'd4,
        ST_ADDR        = 5'd5,
        ST_MEM_RD      = 5'd6,
        ST_MEM_RD_WAIT = 5'd7,
        ST_WB_LD       = 5'd8,
        ST_MEM_WR      = 5'd9,
        ST_BRANCH      = 5'd10,
        ST_JUMP        = 5'd11,
        ST_EXEC_I      = 5'd12,
        ST_EXEC_X      = 5'd13,
        ST_WB_I        = 5'd14,
        ST_EXC         = 5'd15,
        ST_EXC_OVF     = 5'd16,
        ST_HALT        = 5'd17
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SXORI = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_HALT  = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_XOR   = 3'b011;

    // Only the signed R-type arithmetic ops trap on overflow.
    function automatic logic funct_traps(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle CPU control FSM: state register plus combinational next-state
// and Moore output decode (PCWrite in BRANCH additionally follows Zero).
module control_unit
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       EPCWrite,
    output logic       ExcCause,
    output logic [4:0] State
);

    state_t state_r;
    state_t state_nxt_s;

    // State register, forced to FETCH asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign State = state_r;

    // Next-state and output decode.
    always_comb begin
        state_nxt_s = ST_FETCH;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = ALUOP_ADD;
        EPCWrite    = 1'b0;
        ExcCause    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                state_nxt_s = ST_FETCH_WAIT;
            end
            ST_FETCH_WAIT: begin
                IRWrite     = 1'b1;
                PCWrite     = 1'b1;
                ALUSrcB     = 2'b01;
                state_nxt_s = ST_DECODE;
            end
            ST_DECODE: begin
                // Speculative branch target lands in ALUOut.
                ALUSrcB = 2'b11;
                case (Opcode)
                    OP_RTYPE: begin
                        if (Funct == FN_HALT) begin
                            state_nxt_s = ST_HALT;
                        end else begin
                            state_nxt_s = ST_EXEC_R;
                        end
                    end
                    OP_LW, OP_SW:     state_nxt_s = ST_ADDR;
                    OP_BEQ, OP_BNE:   state_nxt_s = ST_BRANCH;
                    OP_J:             state_nxt_s = ST_JUMP;
                    OP_ADDI, OP_ADDIU: state_nxt_s = ST_EXEC_I;
                    OP_SXORI:         state_nxt_s = ST_EXEC_X;
                    default:          state_nxt_s = ST_EXC;
                endcase
            end
            ST_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                if (Overflow && funct_traps(Funct)) begin
                    state_nxt_s = ST_EXC_OVF;
                end else begin
                    state_nxt_s = ST_WB_R;
                end
            end
            ST_WB_R: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ST_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Opcode == OP_LW) begin
                    state_nxt_s = ST_MEM_RD;
                end else begin
                    state_nxt_s = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                IorD        = 1'b1;
                state_nxt_s = ST_MEM_RD_WAIT;
            end
            ST_MEM_RD_WAIT: begin
                IorD        = 1'b1;
                state_nxt_s = ST_WB_LD;
            end
            ST_WB_LD: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            ST_MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSource = 2'b01;
                if (Opcode == OP_BNE) begin
                    PCWrite = ~Zero;
                end else begin
                    PCWrite = Zero;
                end
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ST_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Overflow && (Opcode == OP_ADDI)) begin
                    state_nxt_s = ST_EXC_OVF;
                end else begin
                    state_nxt_s = ST_WB_I;
                end
            end
            ST_EXEC_X: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALUOp       = ALUOP_XOR;
                state_nxt_s = ST_WB_I;
            end
            ST_WB_I: begin
                RegWrite = 1'b1;
            end
            ST_EXC, ST_EXC_OVF: begin
                // ALU computes PC - 4 so EPC points at the faulting instruction.
                ALUSrcB  = 2'b01;
                ALUOp    = ALUOP_SUB;
                EPCWrite = 1'b1;
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                ExcCause = (state_r == ST_EXC_OVF) ? 1'b1 : 1'b0;
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit: walks each instruction class through
// its state sequence and checks State plus every control output per cycle.
module tb_control_unit;
    import cpu_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, EPCWrite, ExcCause;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [4:0] State;

    int n_cmp = 0;
    int n_err = 0;

    control_unit dut (
        .clk(clk), .reset_n(reset_n), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .Overflow(Overflow), .PCWrite(PCWrite), .IorD(IorD),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
        .EPCWrite(EPCWrite), .ExcCause(ExcCause), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //  ALUSrcB[1:0],PCSource[1:0],ALUOp[2:0],EPCWrite,ExcCause}
    logic [16:0] obs_ctl;
    assign obs_ctl = {PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                      ALUSrcA, ALUSrcB, PCSource, ALUOp, EPCWrite, ExcCause};

    localparam logic [16:0] C_ZERO   = 17'b0;
    localparam logic [16:0] C_FW     = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_EXR    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b010,1'b0,1'b0};
    localparam logic [16:0] C_WBR    = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_MRD    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_WBLD   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_MWR    = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_BR0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b001,1'b0,1'b0};
    localparam logic [16:0] C_BR1    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b001,1'b0,1'b0};
    localparam logic [16:0] C_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_EXI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_EXX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b011,1'b0,1'b0};
    localparam logic [16:0] C_WBI    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0};
    localparam logic [16:0] C_EXC    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b11,3'b001,1'b1,1'b0};
    localparam logic [16:0] C_EXCOVF = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b11,3'b001,1'b1,1'b1};

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input state_t st, input logic [16:0] c);
        check({tag, ".state"}, 32'(State), 32'(st));
        check({tag, ".ctl"}, 32'(obs_ctl), 32'(c));
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
        Opcode   = op;
        Funct    = fn;
        Zero     = z;
        Overflow = ov;
    endtask

    task automatic front(input string tag);
        cyc({tag, ".f"}, ST_FETCH, C_ZERO);
        cyc({tag, ".fw"}, ST_FETCH_WAIT, C_FW);
        cyc({tag, ".dec"}, ST_DECODE, C_DEC);
    endtask

    // Asynchronous reset pulse between clock edges, then release on the falling edge.
    task automatic reset_pulse(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check({tag, ".rst_state"}, 32'(State), 32'(ST_FETCH));
        check({tag, ".rst_ctl"}, 32'(obs_ctl), 32'(C_ZERO));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.state", 32'(State), 32'(ST_FETCH));
        check("reset.ctl", 32'(obs_ctl), 32'(C_ZERO));
        @(negedge clk);
        reset_n = 1'b1;

        // add, no overflow
        front("add");
        cyc("add.exr", ST_EXEC_R, C_EXR);
        cyc("add.wbr", ST_WB_R, C_WBR);

        set_in(OP_LW, 6'h00, 1'b0, 1'b0);
        front("lw");
        cyc("lw.addr", ST_ADDR, C_ADDR);
        cyc("lw.mrd", ST_MEM_RD, C_MRD);
        cyc("lw.mrdw", ST_MEM_RD_WAIT, C_MRD);
        cyc("lw.wbld", ST_WB_LD, C_WBLD);

        set_in(OP_SW, 6'h00, 1'b0, 1'b0);
        front("sw");
        cyc("sw.addr", ST_ADDR, C_ADDR);
        cyc("sw.mwr", ST_MEM_WR, C_MWR);

        set_in(OP_BEQ, 6'h00, 1'b1, 1'b0);
        front("beq_z1");
        cyc("beq_z1.br", ST_BRANCH, C_BR1);
        set_in(OP_BEQ, 6'h00, 1'b0, 1'b0);
        front("beq_z0");
        cyc("beq_z0.br", ST_BRANCH, C_BR0);
        set_in(OP_BNE, 6'h00, 1'b1, 1'b0);
        front("bne_z1");
        cyc("bne_z1.br", ST_BRANCH, C_BR0);
        set_in(OP_BNE, 6'h00, 1'b0, 1'b0);
        front("bne_z0");
        cyc("bne_z0.br", ST_BRANCH, C_BR1);

        set_in(OP_J, 6'h00, 1'b0, 1'b0);
        front("j");
        cyc("j.jmp", ST_JUMP, C_JMP);

        set_in(OP_ADDI, 6'h00, 1'b0, 1'b0);
        front("addi");
        cyc("addi.exi", ST_EXEC_I, C_EXI);
        cyc("addi.wbi", ST_WB_I, C_WBI);
        set_in(OP_ADDI, 6'h00, 1'b0, 1'b1);
        front("addi_ov");
        cyc("addi_ov.exi", ST_EXEC_I, C_EXI);
        cyc("addi_ov.exc", ST_EXC_OVF, C_EXCOVF);
        set_in(OP_ADDIU, 6'h00, 1'b0, 1'b1);
        front("addiu_ov");
        cyc("addiu_ov.exi", ST_EXEC_I, C_EXI);
        cyc("addiu_ov.wbi", ST_WB_I, C_WBI);
        set_in(OP_SXORI, 6'h00, 1'b0, 1'b1);
        front("sxori");
        cyc("sxori.exx", ST_EXEC_X, C_EXX);
        cyc("sxori.wbi", ST_WB_I, C_WBI);

        set_in(OP_RTYPE, FN_SUB, 1'b0, 1'b1);
        front("sub_ov");
        cyc("sub_ov.exr", ST_EXEC_R, C_EXR);
        cyc("sub_ov.exc", ST_EXC_OVF, C_EXCOVF);
        set_in(OP_RTYPE, FN_ADD, 1'b0, 1'b1);
        front("add_ov");
        cyc("add_ov.exr", ST_EXEC_R, C_EXR);
        cyc("add_ov.exc", ST_EXC_OVF, C_EXCOVF);
        set_in(OP_RTYPE, FN_SUBU, 1'b0, 1'b1);
        front("subu_ov");
        cyc("subu_ov.exr", ST_EXEC_R, C_EXR);
        cyc("subu_ov.wbr", ST_WB_R, C_WBR);

        set_in(6'h3F, 6'h00, 1'b0, 1'b0);
        front("undef");
        cyc("undef.exc", ST_EXC, C_EXC);

        // lw interrupted by reset in MEM_RD
        set_in(OP_LW, 6'h00, 1'b0, 1'b0);
        front("lw_rst");
        cyc("lw_rst.addr", ST_ADDR, C_ADDR);
        check("lw_rst.mrd", 32'(State), 32'(ST_MEM_RD));
        reset_pulse("lw_rst");
        set_in(OP_J, 6'h00, 1'b0, 1'b0);
        front("j_after");
        cyc("j_after.jmp", ST_JUMP, C_JMP);

        // halt held, then reset out of it
        set_in(OP_RTYPE, FN_HALT, 1'b0, 1'b0);
        front("halt");
        for (int i = 0; i < 20; i++) begin
            cyc("halt.hold", ST_HALT, C_ZERO);
        end
        reset_pulse("halt");
        set_in(OP_RTYPE, FN_ADD, 1'b0, 1'b0);
        front("add2");
        cyc("add2.exr", ST_EXEC_R, C_EXR);
        cyc("add2.wbr", ST_WB_R, C_WBR);
        check("end.state", 32'(State), 32'(ST_FETCH));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
